// File: rtl/mux2_rr_arbiter.sv
// Round-robin packet arbiter that owns the select of a 2:1 data mux.
// The grant is held until a packet's last beat, or revoked after TIMEOUT idle cycles.
module mux2_rr_arbiter #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  input  logic              last0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  input  logic              last1,
  output logic              gnt1,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic              err_timeout
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [7:0] TLIM = 8'(TIMEOUT);

  state_t     state, state_nxt;
  logic       last_served, last_served_nxt;
  logic [7:0] tcnt, tcnt_nxt;
  logic       err_nxt;
  logic       cur_req, other_req, transfer;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign sel       = (state == GNT1);
  assign cur_req   = sel ? req1 : req0;
  assign other_req = sel ? req0 : req1;
  assign out_valid = (state != IDLE) & cur_req;
  assign out_data  = sel ? data1 : data0;
  assign out_last  = sel ? last1 : last0;
  assign transfer  = out_valid & out_ready;
  assign gnt0      = (state == GNT0) & req0 & out_ready;
  assign gnt1      = (state == GNT1) & req1 & out_ready;

  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    tcnt_nxt        = tcnt;
    err_nxt         = 1'b0;
    case (state)
      IDLE: begin
        tcnt_nxt = 8'd0;
        if (req0 && req1) state_nxt = last_served ? GNT0 : GNT1;
        else if (req0)    state_nxt = GNT0;
        else if (req1)    state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        if (transfer) begin
          tcnt_nxt = 8'd0;
          // On the last beat hand over to a waiting peer; otherwise keep the grant.
          if (out_last) begin
            last_served_nxt = sel;
            if (other_req) state_nxt = sel ? GNT0 : GNT1;
          end
        end else if (cur_req) begin
          tcnt_nxt = 8'd0;
        end else begin
          tcnt_nxt = sat_inc(tcnt);
          if (sat_inc(tcnt) >= TLIM) begin
            err_nxt         = 1'b1;
            last_served_nxt = sel;
            state_nxt       = IDLE;
            tcnt_nxt        = 8'd0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_served <= 1'b1;
      tcnt        <= 8'd0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_served <= last_served_nxt;
      tcnt        <= tcnt_nxt;
      err_timeout <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Randomized bench for mux2_rr_arbiter against a packet-ownership reference model.
module tb_mux2_rr_arbiter;
  localparam int DW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, last0, last1, out_ready;
  logic [DW-1:0] data0, data1;
  logic          gnt0, gnt1, out_valid, out_last, sel, err_timeout;
  logic [DW-1:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the mux (-1 none), who was served last, idle count.
  int m_owner, m_last_srv, m_cnt;
  bit m_err;

  mux2_rr_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .data0(data0), .last0(last0), .gnt0(gnt0),
    .req1(req1), .data1(data1), .last1(last1), .gnt1(gnt1),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .sel(sel), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_last_srv = 1;
    m_cnt      = 0;
    m_err      = 1'b0;
  endtask

  task automatic check_outputs();
    bit r[2];
    bit e_valid;
    r[0] = req0;
    r[1] = req1;
    e_valid = (m_owner >= 0) && r[m_owner];
    check("out_valid", 32'(out_valid), 32'(e_valid));
    check("sel", 32'(sel), 32'(m_owner == 1));
    check("gnt0", 32'(gnt0), 32'(m_owner == 0 && req0 && out_ready));
    check("gnt1", 32'(gnt1), 32'(m_owner == 1 && req1 && out_ready));
    check("err_timeout", 32'(err_timeout), 32'(m_err));
    check("out_data", 32'(out_data), 32'((m_owner == 1) ? data1 : data0));
    check("out_last", 32'(out_last), 32'((m_owner == 1) ? last1 : last0));
  endtask

  // Advance the model by one clock using the inputs held across the edge.
  task automatic model_step();
    bit r[2];
    bit l[2];
    int x, o;
    r[0] = req0; r[1] = req1;
    l[0] = last0; l[1] = last1;
    m_err = 1'b0;
    if (m_owner < 0) begin
      m_cnt = 0;
      if (r[0] && r[1]) m_owner = 1 - m_last_srv;
      else if (r[0])    m_owner = 0;
      else if (r[1])    m_owner = 1;
    end else begin
      x = m_owner;
      o = 1 - x;
      if (r[x] && out_ready && l[x]) begin
        m_last_srv = x;
        m_cnt      = 0;
        m_owner    = r[o] ? o : x;
      end else if (r[x]) begin
        m_cnt = 0;
      end else begin
        m_cnt++;
        if (m_cnt == TO) begin
          m_err      = 1'b1;
          m_last_srv = x;
          m_owner    = -1;
          m_cnt      = 0;
        end
      end
    end
  endtask

  task automatic drive(input int phase);
    data0 = DW'($urandom);
    data1 = DW'($urandom);
    case (phase)
      0: begin  // continuous contention, single-beat packets
        req0 = 1'b1; req1 = 1'b1; last0 = 1'b1; last1 = 1'b1; out_ready = 1'b1;
      end
      1: begin
        req0 = 1'($urandom); req1 = 1'($urandom);
        last0 = 1'($urandom); last1 = 1'($urandom); out_ready = 1'($urandom);
      end
      2: begin  // multi-beat packets with moderate backpressure
        req0 = ($urandom % 10) != 0; req1 = ($urandom % 10) != 0;
        last0 = ($urandom % 4) == 0; last1 = ($urandom % 4) == 0;
        out_ready = ($urandom % 10) < 7;
      end
      3: begin  // sparse requests so grants time out
        req0 = ($urandom % 100) < 6; req1 = ($urandom % 100) < 6;
        last0 = ($urandom % 3) == 0; last1 = ($urandom % 3) == 0;
        out_ready = 1'b1;
      end
      default: begin  // heavy backpressure
        req0 = ($urandom % 8) != 0; req1 = ($urandom % 8) != 0;
        last0 = ($urandom % 3) == 0; last1 = ($urandom % 3) == 0;
        out_ready = ($urandom % 5) == 0;
      end
    endcase
  endtask

  // Called at posedge+1: pull rst_n low between edges with both requesters active.
  task automatic async_reset();
    req0 = 1'b1; req1 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_gnt1", 32'(gnt1), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; last0 = 1'b1; last1 = 1'b1;
    data0 = 8'h5A; data1 = 8'hC3; out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_gnt0", 32'(gnt0), 32'd0);
    check("reset_gnt1", 32'(gnt1), 32'd0);
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_err", 32'(err_timeout), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 2000; i++) begin
      if (i == 777 || i == 1555) async_reset();
      drive((i / 250) % 5);
      @(negedge clk);
      check_outputs();
      model_step();
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
